// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: architectural word, register selector and the
// register-file bulk-clear FSM state encoding.
package cpu_types_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef logic [XLEN-1:0]               word_t;
  typedef logic [$clog2(NREGS_DEF)-1:0]  regsel_t;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/register_file_mp.sv
// Multi-ported register file with write-through read bypass, per-register
// scoreboard busy bits and a one-register-per-cycle bulk clear sequencer.
module register_file_mp
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned WIDTH    = $bits(word_t),
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned SELW    = $clog2(NREGS)
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [NWRITE-1:0]                 wen,
  input  logic [NWRITE-1:0][SELW-1:0]       wsel,
  input  logic [NWRITE-1:0][WIDTH-1:0]      wdat,
  input  logic [NREAD-1:0][SELW-1:0]        rsel,
  output logic [NREAD-1:0][WIDTH-1:0]       rdat,
  output logic [NREAD-1:0]                  busy,
  input  logic                              rsv_en,
  input  logic [SELW-1:0]                   rsv_sel,
  input  logic                              clr_req,
  output logic                              clr_busy,
  output logic                              clr_done
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NREGS - 1);
  localparam bit              HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  clr_state_t       state_q, state_d;
  logic [SELW-1:0]  cnt_q, cnt_d;
  logic             clr_busy_q, clr_busy_d;
  logic             clr_done_q, clr_done_d;
  logic             clearing;

  function automatic logic is_zero(input logic [SELW-1:0] sel);
    return HAS_ZERO && (sel == '0);
  endfunction

  assign clearing = (state_q == CLR_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE:  if (clr_req) state_d = CLR_CLEAR;
      CLR_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = CLR_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + SELW'(1);
        end
      end
      CLR_DONE:  state_d = CLR_IDLE;
      default:   state_d = CLR_IDLE;
    endcase
    // Status outputs are registered from the next state so they track state_q.
    clr_busy_d = (state_d == CLR_CLEAR);
    clr_done_d = (state_d == CLR_DONE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= CLR_IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Ascending port order gives port 1 priority; the reserve is applied last so
  // a same-cycle reserve overrides the busy clear from a write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (clearing) begin
      regs_d[cnt_q] = '0;
      busy_d[cnt_q] = 1'b0;
    end else begin
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (wen[j] && !is_zero(wsel[j])) begin
          regs_d[wsel[j]] = wdat[j];
          busy_d[wsel[j]] = 1'b0;
        end
      end
      if (rsv_en && !is_zero(rsv_sel)) busy_d[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rdat = '0;
    busy = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rdat[i] = regs_q[rsel[i]];
      busy[i] = busy_q[rsel[i]];
      if (!clearing) begin
        for (int unsigned j = 0; j < NWRITE; j++) begin
          if (wen[j] && (wsel[j] == rsel[i]) && !is_zero(wsel[j])) rdat[i] = wdat[j];
        end
      end
      if (is_zero(rsel[i])) begin
        rdat[i] = '0;
        busy[i] = 1'b0;
      end
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule
